// File: rtl/rfdc_phase_gen_pkg.sv
// rfdc_phase_gen_pkg: shared widths, parameter-set struct and lane slicing helper for the RFDC phase generator
package rfdc_phase_gen_pkg;

    localparam int LANES       = 16;
    localparam int LG          = $clog2(LANES);
    localparam int FTW_W       = 40;
    localparam int PHASE_OUT_W = 16;
    localparam int AMP_W       = 14;
    localparam int PARAM_W     = 2 * FTW_W + 2 * AMP_W;

    typedef logic [FTW_W-1:0] ftw_t;
    typedef logic [AMP_W-1:0] amp_t;

    // freq sits in the LSBs of the stream word, offset in the MSBs
    typedef struct packed {
        amp_t offset;
        amp_t amp;
        ftw_t phase;
        ftw_t freq;
    } dds_param_t;

    // DDS takes the top bits of each lane phase, truncated
    function automatic logic [PHASE_OUT_W-1:0] phase_msbs(input ftw_t p);
        return p[FTW_W-1 -: PHASE_OUT_W];
    endfunction

endpackage

// File: rtl/rfdc_phase_gen_if.sv
// rfdc_phase_gen_if: parameter update stream in, per-lane phase words plus aligned amp/offset out
interface rfdc_phase_gen_if;
    import rfdc_phase_gen_pkg::*;

    logic [PARAM_W-1:0]           s_axis_param_tdata;
    logic                         s_axis_param_tuser;
    logic                         s_axis_param_tvalid;
    logic                         s_axis_param_tready;
    logic [LANES*PHASE_OUT_W-1:0] m_axis_phase_tdata;
    logic                         m_axis_phase_tvalid;
    amp_t                         amp_out;
    amp_t                         offset_out;

    modport master (
        output s_axis_param_tdata, s_axis_param_tuser, s_axis_param_tvalid,
        input  s_axis_param_tready, m_axis_phase_tdata, m_axis_phase_tvalid, amp_out, offset_out
    );

    modport slave (
        input  s_axis_param_tdata, s_axis_param_tuser, s_axis_param_tvalid,
        output s_axis_param_tready, m_axis_phase_tdata, m_axis_phase_tvalid, amp_out, offset_out
    );

endinterface

// File: rtl/rfdc_phase_gen_lane_mult.sv
// rfdc_phase_gen_lane_mult: registered per-lane offsets i*freq (mod 2^FTW_W), reloaded only on a parameter change
module rfdc_phase_gen_lane_mult
    import rfdc_phase_gen_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  ftw_t                   freq,
    output ftw_t [LANES-1:0]       mult
);

    ftw_t [LANES-1:0] mult_q, mult_d;
    ftw_t             prod;

    // shift-add of freq for each lane index; held between loads so it stays off the per-cycle path
    always_comb begin
        prod   = '0;
        mult_d = mult_q;
        for (int i = 0; i < LANES; i++) begin
            prod = '0;
            for (int b = 0; b < LG; b++) begin
                prod = i[b] ? prod + (freq << b) : prod;
            end
            mult_d[i] = load ? prod : mult_q[i];
        end
    end

    // lane offset registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mult_q <= '0;
        end else begin
            mult_q <= mult_d;
        end
    end

    assign mult = mult_q;

endmodule

// File: rtl/rfdc_phase_gen.sv
// rfdc_phase_gen: 16-lane phase accumulator feeding the RFDC DDS, with handshaked parameter updates
module rfdc_phase_gen
    import rfdc_phase_gen_pkg::*;
(
    input  logic               CLK100MHz,
    input  logic               resetn,
    input  logic               en,
    rfdc_phase_gen_if.slave    bus
);

    dds_param_t       shadow_q, shadow_d;
    dds_param_t       active_q, active_d;
    logic             clr_q, clr_d;
    logic             pending_q, pending_d;
    logic             configured_q, configured_d;
    logic             load_q, load_d;
    ftw_t             acc_q, acc_d;
    ftw_t             base_q, base_d;
    amp_t             amp1_q, amp1_d, off1_q, off1_d;
    amp_t             amp2_q, amp2_d, off2_q, off2_d;
    logic             v1_q, v1_d, v2_q, v2_d;
    ftw_t             lane_q [LANES];
    ftw_t             lane_d [LANES];
    ftw_t [LANES-1:0] mult;
    logic             accept;
    logic             v0;

    // lane offsets reload one cycle after apply so they meet the first base built from the new set
    rfdc_phase_gen_lane_mult u_mult (
        .clk   (CLK100MHz),
        .rst_n (resetn),
        .load  (load_q),
        .freq  (active_q.freq),
        .mult  (mult)
    );

    // handshake, shadow/active parameter sets and accumulator
    always_comb begin
        accept       = bus.s_axis_param_tvalid & ~pending_q;
        shadow_d     = accept ? dds_param_t'(bus.s_axis_param_tdata) : shadow_q;
        clr_d        = accept ? bus.s_axis_param_tuser : clr_q;
        pending_d    = accept;
        active_d     = pending_q ? shadow_q : active_q;
        configured_d = configured_q | pending_q;
        load_d       = pending_q;
        acc_d        = (pending_q & clr_q) ? '0 :
                       en                  ? acc_q + (active_q.freq << LG) : acc_q;
    end

    // two-stage pipeline: base phase, then per-lane phase; amp/offset/valid ride alongside
    always_comb begin
        v0     = en & configured_q;
        v1_d   = v0;
        v2_d   = v1_q;
        base_d = acc_q + active_q.phase;
        amp1_d = active_q.amp;
        off1_d = active_q.offset;
        amp2_d = amp1_q;
        off2_d = off1_q;
        for (int i = 0; i < LANES; i++) begin
            lane_d[i] = base_q + mult[i];
        end
    end

    // state registers
    always_ff @(posedge CLK100MHz or negedge resetn) begin
        if (!resetn) begin
            shadow_q     <= '0;
            active_q     <= '0;
            clr_q        <= 1'b0;
            pending_q    <= 1'b0;
            configured_q <= 1'b0;
            load_q       <= 1'b0;
            acc_q        <= '0;
            base_q       <= '0;
            amp1_q       <= '0;
            off1_q       <= '0;
            amp2_q       <= '0;
            off2_q       <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            clr_q        <= clr_d;
            pending_q    <= pending_d;
            configured_q <= configured_d;
            load_q       <= load_d;
            acc_q        <= acc_d;
            base_q       <= base_d;
            amp1_q       <= amp1_d;
            off1_q       <= off1_d;
            amp2_q       <= amp2_d;
            off2_q       <= off2_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            for (int i = 0; i < LANES; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    // pack the lane phase MSBs onto the output bus
    always_comb begin
        bus.m_axis_phase_tdata = '0;
        for (int i = 0; i < LANES; i++) begin
            bus.m_axis_phase_tdata[i*PHASE_OUT_W +: PHASE_OUT_W] = phase_msbs(lane_q[i]);
        end
    end

    assign bus.s_axis_param_tready = ~pending_q;
    assign bus.m_axis_phase_tvalid = v2_q;
    assign bus.amp_out             = amp2_q;
    assign bus.offset_out          = off2_q;

endmodule

// File: tb/tb_rfdc_phase_gen.sv
// tb_rfdc_phase_gen: scoreboard bench for the RFDC phase generator
module tb_rfdc_phase_gen;
    import rfdc_phase_gen_pkg::*;

    localparam int DW = LANES * PHASE_OUT_W;

    typedef struct {
        logic [DW-1:0] data;
        amp_t          amp;
        amp_t          off;
        int            due;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    logic en     = 1'b0;

    rfdc_phase_gen_if bus();

    rfdc_phase_gen dut (
        .CLK100MHz (clk),
        .resetn    (resetn),
        .en        (en),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    exp_t          q[$];
    int            n_chk = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            acc_edge = 0;
    logic          m_pending, m_conf, m_sclr, accepted;
    dds_param_t    m_shadow, m_active;
    ftw_t          m_acc;
    logic [DW-1:0] last_data, prev_data;
    amp_t          last_amp;
    logic          last_valid;

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [PHASE_OUT_W-1:0] lane(input logic [DW-1:0] d, input int i);
        return d[i*PHASE_OUT_W +: PHASE_OUT_W];
    endfunction

    // one clock: predict this cycle's block, advance the model at the edge, compare at the falling edge
    task automatic tick();
        exp_t e;
        ftw_t l, acc_n;
        logic acc_now;
        accepted = 1'b0;
        if (resetn) begin
            check("tready", bus.s_axis_param_tready, !m_pending);
            if (en && m_conf) begin
                for (int i = 0; i < LANES; i++) begin
                    l = m_acc + m_active.phase + ftw_t'(i) * m_active.freq;
                    e.data[i*PHASE_OUT_W +: PHASE_OUT_W] = l[FTW_W-1 -: PHASE_OUT_W];
                end
                e.amp = m_active.amp;
                e.off = m_active.offset;
                e.due = cyc + 2;
                q.push_back(e);
            end
        end
        @(posedge clk);
        cyc++;
        if (resetn) begin
            acc_now = bus.s_axis_param_tvalid && !m_pending;
            acc_n   = (m_pending && m_sclr) ? '0 : en ? m_acc + ftw_t'(m_active.freq * LANES) : m_acc;
            if (m_pending) begin
                m_active = m_shadow;
                m_conf   = 1'b1;
            end
            if (acc_now) begin
                m_shadow = dds_param_t'(bus.s_axis_param_tdata);
                m_sclr   = bus.s_axis_param_tuser;
                acc_edge = cyc;
            end
            m_pending = acc_now;
            m_acc     = acc_n;
            accepted  = acc_now;
        end
        @(negedge clk);
        last_valid = bus.m_axis_phase_tvalid;
        prev_data  = last_data;
        last_data  = bus.m_axis_phase_tdata;
        last_amp   = bus.amp_out;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            check("tvalid", bus.m_axis_phase_tvalid, 1'b1);
            check("tdata", bus.m_axis_phase_tdata, e.data);
            check("amp", bus.amp_out, e.amp);
            check("offset", bus.offset_out, e.off);
        end else begin
            check("tvalid", bus.m_axis_phase_tvalid, 1'b0);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        check("rst_tvalid", bus.m_axis_phase_tvalid, 1'b0);
        check("rst_tdata", bus.m_axis_phase_tdata, '0);
        check("rst_amp", bus.amp_out, '0);
        check("rst_offset", bus.offset_out, '0);
        check("rst_tready", bus.s_axis_param_tready, 1'b1);
        m_pending = 1'b0;
        m_conf    = 1'b0;
        m_sclr    = 1'b0;
        m_shadow  = '0;
        m_active  = '0;
        m_acc     = '0;
        q.delete();
        repeat (2) tick();
        resetn = 1'b1;
    endtask

    task automatic send(input ftw_t f, input ftw_t p, input amp_t a, input amp_t o, input logic clr);
        bus.s_axis_param_tdata  = {o, a, p, f};
        bus.s_axis_param_tuser  = clr;
        bus.s_axis_param_tvalid = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 8 && !accepted; k++) tick();
        check("accept", accepted, 1'b1);
        bus.s_axis_param_tvalid = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, a2, lows;
        logic [PHASE_OUT_W-1:0] sp_new, sp_old, l0_new, l0_old;
        bus.s_axis_param_tdata  = '0;
        bus.s_axis_param_tuser  = 1'b0;
        bus.s_axis_param_tvalid = 1'b0;
        last_valid = 1'b0;
        last_data  = '0;
        last_amp   = '0;
        @(negedge clk);
        do_reset();
        // idle after reset: nothing may come out without an applied update
        en = 1'b1;
        repeat (100) tick();
        // coherent start at one phase LSB per lane
        send(40'h00_0100_0000, '0, 14'h100, 14'h010, 1'b1);
        for (int k = 0; k < 10 && !last_valid; k++) tick();
        check("t2_lat", cyc - acc_edge, 3);
        check("t2_l0", lane(last_data, 0), 0);
        check("t2_l7", lane(last_data, 7), 7);
        check("t2_l15", lane(last_data, 15), 15);
        tick();
        check("t2_next0", lane(last_data, 0), 16);
        check("t2_next15", lane(last_data, 15), 31);
        repeat (20) tick();
        // phase-continuous switch to double frequency
        send(40'h00_0200_0000, '0, 14'h200, 14'h020, 1'b0);
        for (int k = 0; k < 10 && last_amp != 14'h200; k++) tick();
        check("t4_amp", last_amp, 14'h200);
        sp_new = lane(last_data, 1) - lane(last_data, 0);
        sp_old = lane(prev_data, 1) - lane(prev_data, 0);
        l0_new = lane(last_data, 0);
        l0_old = lane(prev_data, 0) + 16'd16;
        check("t4_sp_new", sp_new, 2);
        check("t4_sp_old", sp_old, 1);
        check("t4_cont", l0_new, l0_old);
        repeat (20) tick();
        // back-to-back updates with tvalid held high
        send(40'h00_1234_5678, 40'h12_0000_0000, 14'd1, 14'd2, 1'b0);
        a0 = acc_edge;
        send(40'h80_0000_0001, 40'hFF_FFFF_FFFF, 14'd3, 14'd4, 1'b1);
        a1 = acc_edge;
        send(40'h00_0000_0100, 40'h55_5555_5555, 14'd5, 14'd6, 1'b0);
        a2 = acc_edge;
        check("t5_gap1", a1 - a0, 2);
        check("t5_gap2", a2 - a1, 2);
        repeat (20) tick();
        // en low for 5 cycles: valid gap of 5, lagging by 2
        lows = 0;
        en = 1'b0;
        repeat (5) begin tick(); lows += int'(!last_valid); end
        en = 1'b1;
        repeat (5) begin tick(); lows += int'(!last_valid); end
        check("t6_lows", lows, 5);
        repeat (10) tick();
        // block step of 2^40 wraps to zero: every block identical
        send(40'h10_0000_0000, '0, 14'd7, 14'd8, 1'b1);
        repeat (10000) tick();
        check("t3_l0", lane(last_data, 0), 16'h0000);
        check("t3_l1", lane(last_data, 1), 16'h1000);
        check("t3_l15", lane(last_data, 15), 16'hF000);
        // mid-run reset: outputs drop at once and stay idle until a new update
        do_reset();
        repeat (100) tick();
        check("t6_idle", last_valid, 1'b0);
        send(40'h00_0100_0000, 40'h00_8000_0000, 14'd9, 14'd10, 1'b1);
        repeat (10) tick();
        en = 1'b0;
        repeat (5) tick();
        check("drain", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
